// File: rtl/ppu_raster_timing.sv
// Raster timing and PPUSTATUS flag generator for the PPU.
// Walks dot/line counters over NTSC, PAL or Dendy frame geometry, applies the
// NTSC odd-frame dot skip, and maintains vblank / sprite-0 / overflow flags
// together with the NMI level and edge pulse.
// Ports:
//   clk, rst_n                 PPU clock, asynchronous active-low reset
//   mode                       requested geometry, loaded at frame wrap
//   rendering_en, nmi_en       render enable, PPUCTRL NMI enable
//   status_rd                  PPUSTATUS read strobe
//   set_spr0_hit, set_spr_ovf  sprite flag set events
//   dot, line                  current raster position
//   status_data                {vblank, spr0_hit, spr_ovf} captured on read
//   vblank, nmi, nmi_pulse     vblank flag, NMI level, NMI rising-edge pulse
//   odd_frame, mode_q          frame parity, active geometry
//   frame_start, frame_end, visible, prerender  position decodes
module ppu_raster_timing #(
  parameter int unsigned CNT_W          = 9,
  parameter int unsigned H_TOTAL        = 341,
  parameter int unsigned V_TOTAL_NTSC   = 262,
  parameter int unsigned V_TOTAL_PAL    = 312,
  parameter int unsigned VBL_LINE_NTSC  = 241,
  parameter int unsigned VBL_LINE_DENDY = 291,
  parameter int unsigned VIS_LINES      = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             rendering_en,
  input  logic             nmi_en,
  input  logic             status_rd,
  input  logic             set_spr0_hit,
  input  logic             set_spr_ovf,
  output logic [CNT_W-1:0] dot,
  output logic [CNT_W-1:0] line,
  output logic [2:0]       status_data,
  output logic             vblank,
  output logic             nmi,
  output logic             nmi_pulse,
  output logic             odd_frame,
  output logic             frame_start,
  output logic             frame_end,
  output logic             visible,
  output logic             prerender,
  output logic [1:0]       mode_q
);

  localparam int unsigned VIS_DOT_MAX = 256;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SKIP    = CNT_W'(H_TOTAL - 2);
  localparam logic [CNT_W-1:0] VN_LAST   = CNT_W'(V_TOTAL_NTSC - 1);
  localparam logic [CNT_W-1:0] VP_LAST   = CNT_W'(V_TOTAL_PAL - 1);
  localparam logic [CNT_W-1:0] VBL_N     = CNT_W'(VBL_LINE_NTSC);
  localparam logic [CNT_W-1:0] VBL_D     = CNT_W'(VBL_LINE_DENDY);
  localparam logic [CNT_W-1:0] VIS_L     = CNT_W'(VIS_LINES);
  localparam logic [CNT_W-1:0] VIS_DOT_L = CNT_W'(VIS_DOT_MAX);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  localparam logic [1:0] MODE_NTSC  = 2'd0;
  localparam logic [1:0] MODE_DENDY = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  logic [CNT_W-1:0] dot_q, dot_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [1:0]       mode_r_q, mode_r_d;
  logic             odd_q, odd_d;
  logic             vblank_q, vblank_d;
  logic             spr0_q, spr0_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       status_q, status_d;
  logic             nmi_q, nmi_d;
  logic             nmi_pulse_q, nmi_pulse_d;

  logic [CNT_W-1:0] v_last;
  logic [CNT_W-1:0] vbl_line;
  logic             at_pre;
  logic             line_end;
  logic             skip;
  logic             wrap;
  logic             vbl_set;
  logic             pre_clr;

  // Geometry selection and position events for the current cycle
  always_comb begin
    v_last   = (mode_r_q == MODE_NTSC) ? VN_LAST : VP_LAST;
    vbl_line = (mode_r_q == MODE_DENDY) ? VBL_D : VBL_N;
    // >= keeps the counters bounded even if the geometry ever shrinks mid-frame
    at_pre   = (line_q >= v_last);
    line_end = (dot_q >= H_LAST);
    skip     = (mode_r_q == MODE_NTSC) && odd_q && rendering_en &&
               at_pre && (dot_q == H_SKIP);
    wrap     = skip || (at_pre && line_end);
    vbl_set  = (line_q == vbl_line) && (dot_q == ONE);
    pre_clr  = at_pre && (dot_q == ONE);
  end

  // Next-state for counters, flags and NMI
  always_comb begin
    dot_d       = dot_q;
    line_d      = line_q;
    mode_r_d    = mode_r_q;
    odd_d       = odd_q;
    vblank_d    = vblank_q;
    spr0_d      = spr0_q;
    ovf_d       = ovf_q;
    status_d    = status_q;
    nmi_d       = 1'b0;
    nmi_pulse_d = 1'b0;

    if (wrap) begin
      dot_d    = '0;
      line_d   = '0;
      odd_d    = ~odd_q;
      mode_r_d = (mode == MODE_RSVD) ? MODE_NTSC : mode;
    end else if (line_end) begin
      dot_d  = '0;
      line_d = line_q + ONE;
    end else begin
      dot_d = dot_q + ONE;
    end

    // A read on the set cycle suppresses the set (read/set race)
    if (status_rd) begin
      vblank_d = 1'b0;
    end else if (vbl_set) begin
      vblank_d = 1'b1;
    end else if (pre_clr) begin
      vblank_d = 1'b0;
    end

    // Pre-render clear takes priority over a coincident set
    if (pre_clr) begin
      spr0_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (set_spr0_hit) spr0_d = 1'b1;
      if (set_spr_ovf)  ovf_d  = 1'b1;
    end

    if (status_rd) begin
      status_d = {vblank_q, spr0_q, ovf_q};
    end

    // NMI tracks the flag as registered this cycle so it rises with vblank
    nmi_d       = vblank_d & nmi_en;
    nmi_pulse_d = nmi_d & ~nmi_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_q       <= '0;
      line_q      <= VN_LAST;
      mode_r_q    <= MODE_NTSC;
      odd_q       <= 1'b0;
      vblank_q    <= 1'b0;
      spr0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      status_q    <= 3'b000;
      nmi_q       <= 1'b0;
      nmi_pulse_q <= 1'b0;
    end else begin
      dot_q       <= dot_d;
      line_q      <= line_d;
      mode_r_q    <= mode_r_d;
      odd_q       <= odd_d;
      vblank_q    <= vblank_d;
      spr0_q      <= spr0_d;
      ovf_q       <= ovf_d;
      status_q    <= status_d;
      nmi_q       <= nmi_d;
      nmi_pulse_q <= nmi_pulse_d;
    end
  end

  assign dot         = dot_q;
  assign line        = line_q;
  assign mode_q      = mode_r_q;
  assign odd_frame   = odd_q;
  assign vblank      = vblank_q;
  assign status_data = status_q;
  assign nmi         = nmi_q;
  assign nmi_pulse   = nmi_pulse_q;

  // Position decodes straight off the registered counters
  assign frame_start = (line_q == '0) && (dot_q == '0);
  assign frame_end   = (line_q == VIS_L) && (dot_q == '0);
  assign visible     = (line_q < VIS_L) && (dot_q != '0) && (dot_q <= VIS_DOT_L);
  assign prerender   = at_pre;

endmodule

// File: tb/tb_ppu_raster_timing.sv
// Scoreboard bench for ppu_raster_timing. A reduced frame geometry keeps each
// frame around a hundred clocks: H=12 dots, NTSC 8 lines, PAL/Dendy 10 lines,
// vblank on line 6 (NTSC/PAL) or 8 (Dendy), 5 visible lines.
module tb_ppu_raster_timing;

  localparam int unsigned CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             rendering_en = 1'b0;
  logic             nmi_en = 1'b1;
  logic             status_rd = 1'b0;
  logic             set_spr0_hit = 1'b0;
  logic             set_spr_ovf = 1'b0;
  logic [CNT_W-1:0] dot;
  logic [CNT_W-1:0] line;
  logic [2:0]       status_data;
  logic             vblank, nmi, nmi_pulse, odd_frame;
  logic             frame_start, frame_end, visible, prerender;
  logic [1:0]       mode_q;

  ppu_raster_timing #(
    .CNT_W(9), .H_TOTAL(12), .V_TOTAL_NTSC(8), .V_TOTAL_PAL(10),
    .VBL_LINE_NTSC(6), .VBL_LINE_DENDY(8), .VIS_LINES(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .rendering_en(rendering_en),
    .nmi_en(nmi_en), .status_rd(status_rd), .set_spr0_hit(set_spr0_hit),
    .set_spr_ovf(set_spr_ovf), .dot(dot), .line(line),
    .status_data(status_data), .vblank(vblank), .nmi(nmi),
    .nmi_pulse(nmi_pulse), .odd_frame(odd_frame), .frame_start(frame_start),
    .frame_end(frame_end), .visible(visible), .prerender(prerender),
    .mode_q(mode_q)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_start = 0;
  logic nmi_prev = 1'b0;
  logic rd_seen = 1'b0;

  int          exp_len[$];
  logic [17:0] exp_rise[$];
  logic [17:0] exp_fall[$];
  logic [2:0]  exp_stat[$];

  function automatic logic [17:0] pos(input int l, input int d);
    logic [8:0] lv, dv;
    lv = 9'(l);
    dv = 9'(d);
    return {lv, dv};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation queued at line %0d dot %0d", name, line, dot);
  endtask

  // Clock count since reset release, and registered view of status_rd
  always @(posedge clk) begin
    if (rst_n) cyc <= cyc + 1;
    rd_seen <= rst_n && status_rd;
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    if (!rst_n) begin
      last_start = cyc;
      nmi_prev   = 1'b0;
    end else begin
      if (frame_start) begin
        if (exp_len.size() == 0) unexpected("frame_len");
        else chk("frame_len", cyc - last_start, exp_len.pop_front());
        last_start = cyc;
      end
      if (nmi_pulse) begin
        if (exp_rise.size() == 0) unexpected("nmi_pulse_pos");
        else chk("nmi_pulse_pos", int'({line, dot}), int'(exp_rise.pop_front()));
      end
      if (nmi_prev && !nmi) begin
        if (exp_fall.size() == 0) unexpected("nmi_fall_pos");
        else chk("nmi_fall_pos", int'({line, dot}), int'(exp_fall.pop_front()));
      end
      if (rd_seen) begin
        if (exp_stat.size() == 0) unexpected("status_data");
        else chk("status_data", int'(status_data), int'(exp_stat.pop_front()));
      end
      nmi_prev = nmi;
    end
  end

  // Advance at least one cycle until the raster reaches (l, d); leaves #1 past negedge
  task automatic wait_pos(input int l, input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(line) == l && int'(dot) == d) && n < 400);
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: line %0d dot %0d not reached, at line %0d dot %0d", l, d, line, dot);
    end
    #1;
  endtask

  // One-cycle strobe: 0=status_rd, 1=set_spr0_hit, 2=set_spr_ovf
  task automatic pulse(input int which);
    case (which)
      0: status_rd = 1'b1;
      1: set_spr0_hit = 1'b1;
      default: set_spr_ovf = 1'b1;
    endcase
    @(negedge clk);
    #1;
    status_rd    = 1'b0;
    set_spr0_hit = 1'b0;
    set_spr_ovf  = 1'b0;
  endtask

  initial begin
    // Frame lengths: partial first frame, NTSC off, skip on odd frames, PAL, Dendy, post-reset
    exp_len = {12, 96, 96, 95, 96, 95, 96, 95, 96, 120, 120, 95, 12};
    exp_rise = {pos(6,2), pos(6,2), pos(6,2), pos(6,2), pos(6,2), pos(6,2),
                pos(6,2), pos(6,2), pos(8,1), pos(8,2), pos(6,2)};
    exp_fall = {pos(7,2), pos(7,2), pos(7,2), pos(7,2), pos(7,2), pos(6,6),
                pos(7,2), pos(7,1), pos(9,2), pos(9,2), pos(6,6)};
    exp_stat = {3'b000, 3'b100, 3'b000, 3'b011, 3'b011, 3'b000, 3'b100};

    repeat (3) @(negedge clk);
    chk("rst_line", int'(line), 7);
    chk("rst_dot", int'(dot), 0);
    chk("rst_mode_q", int'(mode_q), 0);
    chk("rst_vblank", int'(vblank), 0);
    chk("rst_nmi", int'(nmi), 0);
    chk("rst_nmi_pulse", int'(nmi_pulse), 0);
    chk("rst_status", int'(status_data), 0);
    chk("rst_odd", int'(odd_frame), 0);
    chk("rst_prerender", int'(prerender), 1);
    #1 rst_n = 1'b1;

    // Frame 1: position decodes
    wait_pos(0, 0);
    chk("vis_line0_dot0", int'(visible), 0);
    wait_pos(0, 1);
    chk("vis_line0_dot1", int'(visible), 1);
    wait_pos(4, 11);
    chk("vis_line4_dot11", int'(visible), 1);
    wait_pos(5, 0);
    chk("frame_end", int'(frame_end), 1);
    wait_pos(5, 1);
    chk("vis_line5_dot1", int'(visible), 0);
    wait_pos(7, 0);
    chk("prerender_line7", int'(prerender), 1);

    // Frames 2-5: enable rendering on odd frame 3, last pre-render dot skipped
    wait_pos(0, 0);
    wait_pos(0, 0);
    rendering_en = 1'b1;
    wait_pos(7, 10);
    @(negedge clk);
    #1;
    chk("skip_to_origin", int'({line, dot}), int'(pos(0, 0)));
    wait_pos(0, 0);
    wait_pos(0, 0);

    // Frame 6: read on the vblank set cycle suppresses the flag
    wait_pos(6, 1);
    pulse(0);
    wait_pos(6, 5);
    chk("race_vblank", int'(vblank), 0);
    chk("race_nmi", int'(nmi), 0);

    // Frame 7: read during vblank clears it; sprite-0 set loses to pre-render clear
    wait_pos(6, 5);
    pulse(0);
    chk("rd_clears_vblank", int'(vblank), 0);
    wait_pos(7, 1);
    pulse(1);

    // Frame 8: sprite flags set, read twice, cleared at pre-render; request PAL
    wait_pos(1, 3);
    pulse(0);
    wait_pos(2, 4);
    pulse(1);
    wait_pos(3, 0);
    mode = 2'd1;
    pulse(2);
    wait_pos(4, 0);
    pulse(0);
    wait_pos(4, 5);
    pulse(0);
    wait_pos(7, 5);
    pulse(0);

    // Frame 9 (PAL): NMI enable toggled inside vblank re-pulses
    wait_pos(1, 0);
    chk("mode_q_pal", int'(mode_q), 1);
    mode = 2'd2;
    wait_pos(7, 0);
    nmi_en = 1'b0;
    wait_pos(8, 0);
    nmi_en = 1'b1;
    wait_pos(9, 0);
    chk("prerender_pal", int'(prerender), 1);

    // Frame 10 (Dendy), then reserved mode 3 loads as NTSC
    wait_pos(1, 0);
    chk("mode_q_dendy", int'(mode_q), 2);
    mode = 2'd3;
    wait_pos(1, 0);
    chk("mode_q_rsvd", int'(mode_q), 0);
    mode = 2'd1;
    wait_pos(6, 5);
    pulse(0);

    // Frame 12 (PAL): asynchronous reset mid-frame
    wait_pos(3, 0);
    chk("pre_rst_mode_q", int'(mode_q), 1);
    rst_n = 1'b0;
    mode  = 2'd0;
    #1;
    chk("mid_rst_line", int'(line), 7);
    chk("mid_rst_dot", int'(dot), 0);
    chk("mid_rst_mode_q", int'(mode_q), 0);
    chk("mid_rst_status", int'(status_data), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_pos(0, 0);
    repeat (4) @(negedge clk);

    chk("left_frame_len", exp_len.size(), 0);
    chk("left_nmi_rise", exp_rise.size(), 0);
    chk("left_nmi_fall", exp_fall.size(), 0);
    chk("left_status", exp_stat.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
